// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer. Owns the state register and round counter, and drives the SubBytes/ShiftRows, mix-columns and round-key interfaces.
// Optional mix-columns watchdog enabled by defining AES_CTRL_TIMEOUT_EN.
module aes_round_ctrl #(
    parameter int NR         = 10,
    parameter int MC_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         ready,
    output logic [127:0] ciphertext,
    output logic         err,
    output logic [127:0] sb_in,
    input  logic [127:0] sb_out,
    output logic         mc_start,
    output logic [127:0] mc_in,
    input  logic [127:0] mc_out,
    input  logic         mc_ready,
    output logic         rk_req,
    output logic [3:0]   rk_round,
    input  logic         rk_valid,
    input  logic [127:0] rk_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KEY0 = 3'd1;
    localparam logic [2:0] S_SUB  = 3'd2;
    localparam logic [2:0] S_MIX  = 3'd3;
    localparam logic [2:0] S_KEY  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

`ifdef AES_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int            TW       = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);
    localparam logic [3:0]    NR_L     = 4'(NR);

    logic [2:0]    fsm_q, fsm_d;
    logic [3:0]    round_q, round_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  cipher_q, cipher_d;
    logic          err_q, err_d;
    logic          mc_start_q, mc_start_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        // NOTE: every _d starts from its _q (or a fixed value) so no branch of the case can infer a latch.
        fsm_d     = fsm_q;
        round_d   = round_q;
        state_d   = state_q;
        cipher_d  = cipher_q;
        err_d     = err_q;
        tmo_cnt_d = '0;

        case (fsm_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = plaintext;
                    round_d = 4'd0;
                    err_d   = 1'b0;
                    fsm_d   = S_KEY0;
                end
            end
            S_KEY0: begin
                if (rk_valid) begin
                    state_d = state_q ^ rk_data;
                    round_d = 4'd1;
                    fsm_d   = S_SUB;
                end
            end
            S_SUB: begin
                state_d = sb_out;
                fsm_d   = (round_q == NR_L) ? S_KEY : S_MIX;
            end
            S_MIX: begin
                // A ready seen in the launch cycle cannot belong to this operation.
                if (!mc_start_q && mc_ready) begin
                    state_d = mc_out;
                    fsm_d   = S_KEY;
                end else if (TMO_EN && tmo_cnt_q == TMO_LAST) begin
                    cipher_d = '0;
                    err_d    = 1'b1;
                    fsm_d    = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_KEY: begin
                if (rk_valid) begin
                    state_d = state_q ^ rk_data;
                    if (round_q == NR_L) begin
                        cipher_d = state_q ^ rk_data;
                        fsm_d    = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        fsm_d   = S_SUB;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        mc_start_d = (fsm_d == S_MIX) && (fsm_q != S_MIX);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide state and ciphertext registers are reset as well, so an abort leaves all outputs at 0.
            fsm_q      <= S_IDLE;
            round_q    <= 4'd0;
            state_q    <= '0;
            cipher_q   <= '0;
            err_q      <= 1'b0;
            mc_start_q <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            fsm_q      <= fsm_d;
            round_q    <= round_d;
            state_q    <= state_d;
            cipher_q   <= cipher_d;
            err_q      <= err_d;
            mc_start_q <= mc_start_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign busy       = (fsm_q == S_KEY0) || (fsm_q == S_SUB) || (fsm_q == S_MIX) || (fsm_q == S_KEY);
    assign ready      = (fsm_q == S_DONE);
    assign ciphertext = cipher_q;
    assign err        = TMO_EN ? err_q : 1'b0;
    assign sb_in      = state_q;
    assign mc_in      = state_q;
    assign mc_start   = mc_start_q;
    assign rk_req     = (fsm_q == S_KEY0) || (fsm_q == S_KEY);
    assign rk_round   = rk_req ? round_q : 4'd0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl with behavioural AES, key schedule and mix-columns models.
// Define AES_CTRL_TIMEOUT_EN to exercise the mix-columns watchdog.
module tb_aes_round_ctrl;

    localparam int NR         = 10;
    localparam int MC_TIMEOUT = 16;
    localparam logic [127:0] KEY0_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] plaintext = '0;
    logic         busy, ready, err, mc_start, rk_req;
    logic [127:0] ciphertext, sb_in, mc_in;
    logic [3:0]   rk_round;
    logic [127:0] sb_out;
    logic [127:0] mc_out = '0;
    logic [127:0] rk_data = '0;
    logic         mc_ready = 1'b0;
    logic         rk_valid = 1'b0;

    aes_round_ctrl #(.NR(NR), .MC_TIMEOUT(MC_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext),
        .busy(busy), .ready(ready), .ciphertext(ciphertext), .err(err),
        .sb_in(sb_in), .sb_out(sb_out),
        .mc_start(mc_start), .mc_in(mc_in), .mc_out(mc_out), .mc_ready(mc_ready),
        .rk_req(rk_req), .rk_round(rk_round), .rk_valid(rk_valid), .rk_data(rk_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural AES ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, sq);
            sq = gmul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    logic [127:0] rk_tab [0:NR];
    logic [31:0]  w      [0:4*NR+3];

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r < NR; r++) s = mix_cols(sub_shift(s)) ^ rk_tab[r];
        return sub_shift(s) ^ rk_tab[NR];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // External SubBytes+ShiftRows stage is combinational.
    assign sb_out = sub_shift(sb_in);

    // ---------------- environment knobs ----------------
    int mc_lat   = 4;
    int rk_delay = 0;
    bit spur     = 1'b0;
    bit mc_mute  = 1'b0;

    bit mc_in_bad   = 1'b0;
    bit rk_zero_bad = 1'b0;
    bit rk_rng_bad  = 1'b0;
    bit excl_bad    = 1'b0;

    // Mix-columns unit: ready L cycles after the launch cycle.
    initial begin : mc_unit
        logic [127:0] mc_hold;
        int  mc_age;
        bit  mc_act;
        mc_hold = '0;
        mc_age  = 0;
        mc_act  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !busy) mc_act = 1'b0;
            if (rst_n && mc_start) begin
                mc_act  = 1'b1;
                mc_age  = 0;
                mc_hold = mc_in;
            end else if (mc_act) begin
                mc_age++;
                if (mc_in !== mc_hold) mc_in_bad = 1'b1;
            end
            if (mc_act && !mc_start && !mc_mute && mc_age == mc_lat) begin
                mc_ready = 1'b1;
                mc_out   = mix_cols(mc_hold);
                mc_act   = 1'b0;
            end else begin
                mc_ready = spur && !(mc_act && !mc_start);
                mc_out   = rnd128();
            end
        end
    end

    // Round-key provider with configurable delay; logs every key handed over.
    int rk_log[$];
    initial begin : rk_unit
        int rk_wait;
        rk_wait = 0;
        forever begin
            @(negedge clk);
            if (rk_req) begin
                rk_wait++;
                if (int'(rk_round) > NR) rk_rng_bad = 1'b1;
                if (rk_wait > rk_delay && int'(rk_round) <= NR) begin
                    rk_valid = 1'b1;
                    rk_data  = rk_tab[int'(rk_round)];
                    rk_log.push_back(int'(rk_round));
                    rk_wait  = 0;
                end else begin
                    rk_valid = 1'b0;
                    rk_data  = rnd128();
                end
            end else begin
                rk_wait  = 0;
                if (rk_round !== 4'd0) rk_zero_bad = 1'b1;
                rk_valid = spur;
                rk_data  = rnd128();
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] ct;
        logic         err;
        int           lat;
        int           n_mc;
        bit           chk_rk;
    } exp_t;

    exp_t sb_q[$];
    int   start_cyc = 0;
    int   mc_cnt    = 0;
    int   n_done    = 0;

    initial begin : monitor
        logic ready_prev;
        exp_t e;
        int   seq_err;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mc_start) mc_cnt++;
            if (busy && ready) excl_bad = 1'b1;
            if (ready && !ready_prev) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got ready=1 with ct %0h, expected no result", ciphertext);
                end else begin
                    e = sb_q.pop_front();
                    check("ciphertext", ciphertext, e.ct);
                    check("err_at_done", err, e.err);
                    check("latency", cyc - start_cyc, e.lat);
                    check("mc_start_pulses", mc_cnt, e.n_mc);
                    if (e.chk_rk) begin
                        seq_err = (rk_log.size() == NR + 1) ? 0 : 1;
                        for (int i = 0; i < rk_log.size(); i++)
                            if (rk_log[i] != i) seq_err++;
                        check("rk_round_sequence_errors", seq_err, 0);
                    end
                end
                n_done++;
            end
            ready_prev = ready;
        end
    end

    function automatic int lat_of(input int l, input int d);
        return 1 + (NR - 1) * (l + 3) + 2 + (NR + 1) * d;
    endfunction

    function automatic exp_t make_exp(input logic [127:0] ct, input int lat);
        exp_t e;
        e.ct     = ct;
        e.err    = 1'b0;
        e.lat    = lat;
        e.n_mc   = NR - 1;
        e.chk_rk = 1'b1;
        return e;
    endfunction

    task automatic issue(input logic [127:0] pt, input exp_t e);
        @(negedge clk);
        start     = 1'b1;
        plaintext = pt;
        start_cyc = cyc + 1;
        mc_cnt    = 0;
        rk_log.delete();
        sb_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        plaintext = rnd128();
        check("ready_drop_after_start", ready, 1'b0);
        check("busy_after_start", busy, 1'b1);
        check("err_clear_after_start", err, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int target;
        int n;
        target = n_done + 1;
        n = 0;
        while (n_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_done < target) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no ready within %0d cycles, expected ready", budget);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sb_q.delete();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start_at(input int k);
        while (cyc < start_cyc + k - 1) @(negedge clk);
        start     = 1'b1;
        plaintext = rnd128();
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_ciphertext"}, ciphertext, '0);
        check({tag, "_mc_start"}, mc_start, 1'b0);
        check({tag, "_rk_req"}, rk_req, 1'b0);
        check({tag, "_rk_round"}, rk_round, 4'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [127:0] key_v, pt;
        logic [31:0]  t;
        logic [7:0]   rcon;
        exp_t         e;
        int           l, d;

        key_v = KEY0_C;
        rcon  = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key_v[127-32*i -: 32];
        for (int i = 4; i < 4 * (NR + 1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 vector, keys immediate, L=4
        mc_lat = 4; rk_delay = 0;
        issue(PT0, make_exp(CT0, 66));
        wait_done(200);

        // Key back-pressure, restart from DONE
        rk_delay = 3;
        issue(PT0, make_exp(CT0, 99));
        wait_done(300);

        // start pulses while busy are ignored
        rk_delay = 0;
        pt = rnd128();
        issue(pt, make_exp(aes_ref(pt), lat_of(4, 0)));
        pulse_start_at(5);
        pulse_start_at(30);
        wait_done(200);
        repeat (20) @(negedge clk);
        check("no_extra_result", sb_q.size(), 0);

        // async reset mid-MIX, then a clean restart
        pt = rnd128();
        issue(pt, make_exp(aes_ref(pt), 66));
        while (cyc < start_cyc + 20) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pt = rnd128();
        issue(pt, make_exp(aes_ref(pt), 66));
        wait_done(200);

        // spurious mc_ready / rk_valid
        spur = 1'b1;
        do_reset(2);
        repeat (5) @(negedge clk);
        check("spur_idle_busy", busy, 1'b0);
        check("spur_idle_ready", ready, 1'b0);
        check("spur_idle_state", sb_in, '0);
        check("spur_idle_ciphertext", ciphertext, '0);
        pt = rnd128();
        issue(pt, make_exp(aes_ref(pt), 66));
        wait_done(200);
        spur = 1'b0;

        // randomized latencies and key delays
        for (int n = 0; n < 6; n++) begin
            l  = $urandom_range(6, 1);
            d  = $urandom_range(3, 0);
            mc_lat   = l;
            rk_delay = d;
            pt = rnd128();
            issue(pt, make_exp(aes_ref(pt), lat_of(l, d)));
            wait_done(400);
        end

        // mix-columns never answers
        mc_lat = 4; rk_delay = 0; mc_mute = 1'b1;
`ifdef AES_CTRL_TIMEOUT_EN
        e        = make_exp('0, 2 + MC_TIMEOUT);
        e.err    = 1'b1;
        e.n_mc   = 1;
        e.chk_rk = 1'b0;
        issue(rnd128(), e);
        wait_done(100);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1'b1);
        check("ready_after_timeout", ready, 1'b1);
        mc_mute = 1'b0;
        pt = rnd128();
        issue(pt, make_exp(aes_ref(pt), 66));
        wait_done(200);
`else
        e = make_exp(rnd128(), 0);
        issue(rnd128(), e);
        repeat (100) @(negedge clk);
        check("stall_busy", busy, 1'b1);
        check("stall_err", err, 1'b0);
        check("stall_ready", ready, 1'b0);
        mc_mute = 1'b0;
        do_reset(2);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        check("mc_in_stable", mc_in_bad, 1'b0);
        check("rk_round_zero_when_idle", rk_zero_bad, 1'b0);
        check("rk_round_in_range", rk_rng_bad, 1'b0);
        check("busy_ready_exclusive", excl_bad, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
